// File: rtl/div_seq.sv
// div_seq: sequential signed divider (restoring, one quotient bit per clock).
// Quotient goes to lo and remainder to hi, matching the MULT hi/lo convention.
// The quotient truncates toward zero and the remainder takes the dividend's sign.
// Optional build macro DIV_EARLY_OUT_EN: finish in FIX right after acceptance
// when |B| > |A| (this includes A == 0).
module div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   rem, rem_nxt;
  logic [WIDTH-1:0] quot, quot_nxt;
  logic [WIDTH-1:0] babs, babs_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             neg_q, neg_q_nxt;
  logic             neg_r, neg_r_nxt;
  logic             b_zero, b_zero_nxt;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic             busy_nxt, done_nxt, div_zero_nxt;

  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   shifted;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rem      <= '0;
      quot     <= '0;
      babs     <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      b_zero   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_nxt;
      rem      <= rem_nxt;
      quot     <= quot_nxt;
      babs     <= babs_nxt;
      cnt      <= cnt_nxt;
      neg_q    <= neg_q_nxt;
      neg_r    <= neg_r_nxt;
      b_zero   <= b_zero_nxt;
      hi       <= hi_nxt;
      lo       <= lo_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      div_zero <= div_zero_nxt;
    end
  end

  // Next-state logic and datapath update for IDLE / CALC / FIX.
  always_comb begin
    state_nxt    = state;
    rem_nxt      = rem;
    quot_nxt     = quot;
    babs_nxt     = babs;
    cnt_nxt      = cnt;
    neg_q_nxt    = neg_q;
    neg_r_nxt    = neg_r;
    b_zero_nxt   = b_zero;
    hi_nxt       = hi;
    lo_nxt       = lo;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    div_zero_nxt = div_zero;
    a_abs        = A[WIDTH-1] ? -A : A;
    b_abs        = B[WIDTH-1] ? -B : B;
    shifted      = {rem[WIDTH-1:0], quot[WIDTH-1]};

    unique case (state)
      IDLE: begin
        if (start) begin
          babs_nxt     = b_abs;
          quot_nxt     = a_abs;
          rem_nxt      = '0;
          cnt_nxt      = '0;
          neg_q_nxt    = A[WIDTH-1] ^ B[WIDTH-1];
          neg_r_nxt    = A[WIDTH-1];
          b_zero_nxt   = (B == '0);
          busy_nxt     = 1'b1;
          div_zero_nxt = 1'b0;
          if (B == '0) begin
            // The raw dividend is parked in rem so FIX can return it unchanged as hi.
            rem_nxt   = {1'b0, A};
            state_nxt = FIX;
`ifdef DIV_EARLY_OUT_EN
          end else if (b_abs > a_abs) begin
            quot_nxt  = '0;
            rem_nxt   = {1'b0, a_abs};
            state_nxt = FIX;
`endif
          end else begin
            state_nxt = CALC;
          end
        end
      end

      CALC: begin
        if (shifted >= {1'b0, babs}) begin
          rem_nxt  = shifted - {1'b0, babs};
          quot_nxt = {quot[WIDTH-2:0], 1'b1};
        end else begin
          rem_nxt  = shifted;
          quot_nxt = {quot[WIDTH-2:0], 1'b0};
        end
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) state_nxt = FIX;
      end

      FIX: begin
        if (b_zero) begin
          hi_nxt       = rem[WIDTH-1:0];
          lo_nxt       = '1;
          div_zero_nxt = 1'b1;
        end else begin
          lo_nxt = neg_q ? -quot : quot;
          hi_nxt = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
        end
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
